// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one asynchronous 32-bit SRAM between a fetch read
// port (IF) and a load/store port (LS). A three-state FSM (IDLE/ACCESS/DONE)
// serves one access at a time. ACCESS lasts WAIT_CYCLES+1 cycles and DONE
// pulses the granted port's ack.
// Optional macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests
// alternate between ports. When undefined, LS always wins a tie.
module sram_port_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [31:0]       o_if_rdata,
   output logic              o_if_ack,
   input  logic              i_ls_req,
   input  logic              i_ls_wr,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [31:0]       i_ls_wdata,
   input  logic [3:0]        i_ls_bmask,
   output logic [31:0]       o_ls_rdata,
   output logic              o_ls_ack,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [31:0]       o_sram_wdata,
   input  logic [31:0]       i_sram_rdata,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic [3:0]        o_sram_be_n,
   output logic              o_busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_cnt;
   logic              r_grant_ls;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_bmask;
   logic [31:0]       r_if_rdata;
   logic [31:0]       r_ls_rdata;
   logic              w_grant_ls;
   logic              w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
   // r_last_ls = 1 when the most recent grant went to LS; reset means IF.
   logic              r_last_ls;

   // Tie goes to the port that was not granted last.
   always_comb begin
      w_grant_ls = i_ls_req && (!i_if_req || !r_last_ls);
   end
`else
   // Fixed priority: LS wins any tie.
   always_comb begin
      w_grant_ls = i_ls_req;
   end
`endif

   assign w_any_req    = i_if_req || i_ls_req;
   assign o_sram_addr  = r_addr;
   assign o_sram_wdata = r_wdata;
   assign o_if_rdata   = r_if_rdata;
   assign o_ls_rdata   = r_ls_rdata;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic plus strobe and ack decode from the current state.
   always_comb begin
      w_state_next = r_state;
      o_sram_ce_n  = 1'b1;
      o_sram_oe_n  = 1'b1;
      o_sram_we_n  = 1'b1;
      o_sram_be_n  = 4'hF;
      o_if_ack     = 1'b0;
      o_ls_ack     = 1'b0;
      o_busy       = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) w_state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            o_sram_ce_n = 1'b0;
            if (r_wr) begin
               o_sram_we_n = 1'b0;
               o_sram_be_n = ~r_bmask;
            end else begin
               o_sram_oe_n = 1'b0;
               o_sram_be_n = 4'h0;
            end
            if (r_cnt == 3'd0) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            o_if_ack     = !r_grant_ls;
            o_ls_ack     = r_grant_ls;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Transaction latch at grant, wait counter, and read-data capture at the end of ACCESS.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= 3'd0;
         r_grant_ls <= 1'b0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_bmask    <= 4'h0;
         r_if_rdata <= 32'h0;
         r_ls_rdata <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_ls  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant_ls <= w_grant_ls;
                  r_cnt      <= LP_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_ls  <= w_grant_ls;
`endif
                  if (w_grant_ls) begin
                     r_wr    <= i_ls_wr;
                     r_addr  <= i_ls_addr;
                     r_wdata <= i_ls_wdata;
                     r_bmask <= i_ls_bmask;
                  end else begin
                     r_wr    <= 1'b0;
                     r_addr  <= i_if_addr;
                  end
               end
            end
            ST_ACCESS: begin
               if (r_cnt == 3'd0) begin
                  if (!r_wr) begin
                     if (r_grant_ls) r_ls_rdata <= i_sram_rdata;
                     else            r_if_rdata <= i_sram_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: WAIT_CYCLES=2 main instance plus
// a WAIT_CYCLES=0 instance for the back-to-back throughput case.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, ls_req, ls_wr;
   logic [17:0] if_addr, ls_addr;
   logic [31:0] ls_wdata, sram_rdata;
   logic [3:0]  ls_bmask;
   logic [31:0] if_rdata, ls_rdata, sram_wdata;
   logic        if_ack, ls_ack, ce_n, oe_n, we_n, busy;
   logic [17:0] sram_addr;
   logic [3:0]  be_n;

   logic        if_req1;
   logic [31:0] if_rdata1, ls_rdata1, sram_wdata1;
   logic        if_ack1, ls_ack1, ce_n1, oe_n1, we_n1, busy1;
   logic [17:0] sram_addr1;
   logic [3:0]  be_n1;

   int n_checks = 0;
   int n_errors = 0;

   // Observations collected by watch().
   int          first_if, first_ls, n_if, n_ls, n_oe, n_we, n_both;
   logic [3:0]  be_wr;
   logic [31:0] wd_seen;
   logic [17:0] addr_seen;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(2)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
      .i_ls_req(ls_req), .i_ls_wr(ls_wr), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .i_ls_bmask(ls_bmask), .o_ls_rdata(ls_rdata), .o_ls_ack(ls_ack),
      .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
      .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_sram_be_n(be_n),
      .o_busy(busy)
   );

   sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req1), .i_if_addr(18'h00100), .o_if_rdata(if_rdata1), .o_if_ack(if_ack1),
      .i_ls_req(1'b0), .i_ls_wr(1'b0), .i_ls_addr(18'h0), .i_ls_wdata(32'h0),
      .i_ls_bmask(4'h0), .o_ls_rdata(ls_rdata1), .o_ls_ack(ls_ack1),
      .o_sram_addr(sram_addr1), .o_sram_wdata(sram_wdata1), .i_sram_rdata(sram_rdata),
      .o_sram_ce_n(ce_n1), .o_sram_oe_n(oe_n1), .o_sram_we_n(we_n1), .o_sram_be_n(be_n1),
      .o_busy(busy1)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles, recording strobes and acks; a requester drops req when acked.
   task automatic watch(input int n);
      first_if = 0; first_ls = 0; n_if = 0; n_ls = 0;
      n_oe = 0; n_we = 0; n_both = 0;
      be_wr = 4'hx; wd_seen = 32'hx; addr_seen = 18'hx;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (!ce_n) addr_seen = sram_addr;
         if (!oe_n) n_oe++;
         if (!we_n) begin
            n_we++;
            be_wr   = be_n;
            wd_seen = sram_wdata;
         end
         if (if_ack && ls_ack) n_both++;
         if (if_ack) begin
            n_if++;
            if (first_if == 0) first_if = k;
            if_req = 1'b0;
         end
         if (ls_ack) begin
            n_ls++;
            if (first_ls == 0) first_ls = k;
            ls_req = 1'b0;
         end
      end
   endtask

   logic [11:0] ack_vec;

   initial begin
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; if_req1 = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0; sram_rdata = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_strobes", {ce_n, oe_n, we_n, be_n}, 7'h7F);
      check("rst_addr_wdata", {sram_addr, sram_wdata}, 0);
      check("rst_rdata", {if_rdata, ls_rdata}, 0);
      check("rst_acks", {if_ack, ls_ack}, 0);
      rst = 1'b0;
      tick();

      // IF read.
      if_req = 1'b1; if_addr = 18'h00010; sram_rdata = 32'hDEADBEEF;
      watch(8);
      check("if_rd_oe_cycles", n_oe, 3);
      check("if_rd_ack_at", first_if, 4);
      check("if_rd_ack_count", n_if, 1);
      check("if_rd_no_ls_ack", n_ls, 0);
      check("if_rd_addr", addr_seen, 18'h00010);
      check("if_rd_rdata", if_rdata, 32'hDEADBEEF);
      $display("txn IF read addr=0x00010 rdata=0x%08h ack_at=%0d", if_rdata, first_if);

      // LS read to give o_ls_rdata a known value.
      ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 18'h00024; sram_rdata = 32'hCAFEF00D;
      watch(6);
      check("ls_rd_ack_at", first_ls, 4);
      check("ls_rd_rdata", ls_rdata, 32'hCAFEF00D);
      check("ls_rd_if_rdata_kept", if_rdata, 32'hDEADBEEF);
      $display("txn LS read addr=0x00024 rdata=0x%08h", ls_rdata);

      // LS write.
      ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 18'h00020; ls_wdata = 32'h12345678;
      ls_bmask = 4'b0101; sram_rdata = 32'h55555555;
      watch(8);
      check("ls_wr_we_cycles", n_we, 3);
      check("ls_wr_oe_cycles", n_oe, 0);
      check("ls_wr_be_n", be_wr, 4'b1010);
      check("ls_wr_wdata", wd_seen, 32'h12345678);
      check("ls_wr_addr", addr_seen, 18'h00020);
      check("ls_wr_ack_count", n_ls, 1);
      check("ls_wr_rdata_kept", ls_rdata, 32'hCAFEF00D);
      $display("txn LS write addr=0x00020 data=0x12345678 be_n=%b", be_wr);

      // Simultaneous requests: LS first, IF five cycles later.
      ls_wr = 1'b0; ls_addr = 18'h00040; if_addr = 18'h00030; sram_rdata = 32'hA5A5A5A5;
      if_req = 1'b1; ls_req = 1'b1;
      watch(12);
      check("tie_ls_ack_at", first_ls, 4);
      check("tie_if_ack_at", first_if, 9);
      check("tie_never_both", n_both, 0);
      check("tie_ack_counts", {n_if[3:0], n_ls[3:0]}, 8'h11);
      $display("txn tie ls_ack_at=%0d if_ack_at=%0d", first_ls, first_if);

      // Reset in the second ACCESS cycle aborts the access.
      if_req = 1'b1; if_addr = 18'h00050; sram_rdata = 32'h0BADCAFE;
      tick();
      tick();
      check("abort_in_access", {busy, ce_n}, 2'b10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_strobes", {ce_n, oe_n, we_n, be_n}, 7'h7F);
      check("abort_busy_ack", {busy, if_ack, ls_ack}, 0);
      check("abort_rdata_cleared", if_rdata, 0);
      watch(6);
      check("abort_next_ack_at", first_if, 4);
      check("abort_next_rdata", if_rdata, 32'h0BADCAFE);
      $display("txn reset-abort then IF read rdata=0x%08h", if_rdata);

      // WAIT_CYCLES=0, IF request held continuously.
      if_req1 = 1'b1;
      ack_vec = '0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         ack_vec[k-1] = if_ack1;
         if (ls_ack1) ack_vec = 12'hFFF;
      end
      check("w0_ack_pattern", ack_vec, 12'h492);
      if_req1 = 1'b0;
      $display("txn W0 held request ack_pattern=%b", ack_vec);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
